// File: rtl/hflf_switch_seq_pkg.sv
// -----------------------------------------------------------------------------
// hflf_switch_seq_pkg
// Shared definitions for the HF/LF personality changeover sequencer:
//   - state_t  : sequencer states
//   - DEF_*    : default cycle constants (13.56 MHz clock domain)
//   - SEL_HF   : mux-select encoding that routes the HF personality
// -----------------------------------------------------------------------------
package hflf_switch_seq_pkg;

    localparam logic SEL_HF = 1'b1;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1024;
    localparam int DEF_DRAIN_MAX       = 4096;
    localparam int DEF_GUARD_CYCLES    = 13560;  // 1 ms at 13.56 MHz
    localparam int DEF_SETTLE_CYCLES   = 64;
    localparam int DEF_CNT_W           = 16;

    typedef enum logic [2:0] {
        STARTUP,
        ACTIVE,
        DRAIN,
        PWR_OFF,
        SWAP,
        SETTLE
    } state_t;

endpackage

// File: rtl/hflf_switch_seq_sync_debounce.sv
// -----------------------------------------------------------------------------
// hflf_switch_seq_sync_debounce
// Synchronises the asynchronous FPGA_SWITCH pin and debounces it.
// A level is accepted once the synchronised value has matched the registered
// candidate for DEBOUNCE_CYCLES cycles; accept pulses for one cycle on every
// acceptance (including the first one after reset).
// Latency from a clean pin edge to sw_db: SYNC_STAGES + DEBOUNCE_CYCLES + 1.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   pin        : raw asynchronous switch input (1 = HF, 0 = LF)
//   sw_db      : debounced level
//   accept     : one-cycle strobe, sw_db was (re)loaded this cycle
// -----------------------------------------------------------------------------
module hflf_switch_seq_sync_debounce
    import hflf_switch_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic sw_db,
    output logic accept
);

    localparam logic [CNT_W-1:0] DEB_LOAD = CNT_W'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sw_s;
    logic                   cand_q;
    logic [CNT_W-1:0]       cnt_q;

    assign sw_s = sync_q[SYNC_STAGES-1];

    // NOTE: every flop here uses non-blocking assignment so all stages sample
    // the pre-edge values; blocking would collapse the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cand_q <= 1'b0;
            cnt_q  <= DEB_LOAD;
            sw_db  <= SEL_HF;
            accept <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            accept <= 1'b0;
            if (sw_s != cand_q) begin
                cand_q <= sw_s;
                cnt_q  <= DEB_LOAD;
            end else if (cnt_q == CNT_W'(1)) begin
                // Accept on the 1->0 step so the counter ends parked at 0.
                cnt_q  <= '0;
                sw_db  <= cand_q;
                accept <= 1'b1;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hflf_switch_seq.sv
// -----------------------------------------------------------------------------
// hflf_switch_seq
// Sequences the HF/LF personality changeover: drain SSP traffic on the active
// side, gate all antenna power and let the field decay, then swap the output
// mux select while holding the inactive personality in reset.
//
// Build option: define HFLF_DRAIN_WAIT_EN to include the DRAIN state (wait for
// the active side's ssp_frame to go idle, bounded by DRAIN_MAX). Without it,
// ACTIVE goes straight to PWR_OFF, drain_to is tied 0 and the ssp_frame inputs
// are ignored.
//
// Ports:
//   ck_1356meg   : clock
//   nrst         : asynchronous active-low reset
//   fpga_switch  : raw switch pin, asynchronous (1 = HF, 0 = LF)
//   hf_ssp_frame : HF personality ssp_frame (activity)
//   lf_ssp_frame : LF personality ssp_frame (activity)
//   sel_hf       : output mux select, 1 routes HF
//   pwr_gate     : 1 forces all power/antenna outputs low
//   hf_rst_n     : active-low reset to the HF personality
//   lf_rst_n     : active-low reset to the LF personality
//   busy         : high whenever not ACTIVE
//   drain_to     : sticky, a drain ended on timeout (cleared by nrst only)
// -----------------------------------------------------------------------------
module hflf_switch_seq
    import hflf_switch_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DRAIN_MAX       = DEF_DRAIN_MAX,
    parameter int GUARD_CYCLES    = DEF_GUARD_CYCLES,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic ck_1356meg,
    input  logic nrst,
    input  logic fpga_switch,
    input  logic hf_ssp_frame,
    input  logic lf_ssp_frame,
    output logic sel_hf,
    output logic pwr_gate,
    output logic hf_rst_n,
    output logic lf_rst_n,
    output logic busy,
    output logic drain_to
);

    localparam logic [CNT_W-1:0] LD_DEB    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LD_GUARD  = CNT_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_d, hf_rst_d, lf_rst_d;
    logic             sw_db, sw_acc;
    logic             cnt_done;

    hflf_switch_seq_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sync_debounce (
        .clk    (ck_1356meg),
        .rst_n  (nrst),
        .pin    (fpga_switch),
        .sw_db  (sw_db),
        .accept (sw_acc)
    );

    // A state loaded with N on entry is left on the edge where the counter
    // would step 1->0, so it is occupied for exactly N cycles.
    assign cnt_done = (cnt_q <= CNT_W'(1));

`ifdef HFLF_DRAIN_WAIT_EN
    localparam logic [CNT_W-1:0] LD_DRAIN = CNT_W'(DRAIN_MAX);

    logic act_frame, frame_q, drain_idle, drain_to_d;

    assign act_frame  = (sel_hf == SEL_HF) ? hf_ssp_frame : lf_ssp_frame;
    // Idle means the active side's frame was low this cycle and the last one.
    assign drain_idle = !act_frame && !frame_q;

    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            frame_q  <= 1'b1;
            drain_to <= 1'b0;
        end else begin
            frame_q  <= act_frame;
            drain_to <= drain_to_d;
        end
    end
`else
    logic unused_drain;
    assign unused_drain = ^{hf_ssp_frame, lf_ssp_frame, CNT_W'(DRAIN_MAX)};
    assign drain_to     = 1'b0;
`endif

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        sel_d    = sel_hf;
        hf_rst_d = hf_rst_n;
        lf_rst_d = lf_rst_n;
`ifdef HFLF_DRAIN_WAIT_EN
        drain_to_d = drain_to;
`endif
        case (state_q)
            STARTUP: begin
                if (sw_acc) begin
                    state_d  = SETTLE;
                    cnt_d    = LD_SETTLE;
                    sel_d    = sw_db;
                    hf_rst_d = (sw_db == SEL_HF);
                    lf_rst_d = (sw_db != SEL_HF);
                end
            end
            ACTIVE: begin
                if (sw_db != sel_hf) begin
`ifdef HFLF_DRAIN_WAIT_EN
                    state_d  = DRAIN;
                    cnt_d    = LD_DRAIN;
`else
                    state_d  = PWR_OFF;
                    cnt_d    = LD_GUARD;
                    hf_rst_d = 1'b0;
                    lf_rst_d = 1'b0;
`endif
                end
            end
`ifdef HFLF_DRAIN_WAIT_EN
            DRAIN: begin
                // A reverted pin wins: nothing has been gated yet.
                if (sw_db == sel_hf) begin
                    state_d = ACTIVE;
                end else if (drain_idle || cnt_done) begin
                    state_d  = PWR_OFF;
                    cnt_d    = LD_GUARD;
                    hf_rst_d = 1'b0;
                    lf_rst_d = 1'b0;
                    if (!drain_idle) drain_to_d = 1'b1;
                end
            end
`endif
            PWR_OFF: begin
                if (cnt_done) begin
                    state_d = SWAP;
                    sel_d   = ~sel_hf;
                end
            end
            SWAP: begin
                state_d  = SETTLE;
                cnt_d    = LD_SETTLE;
                hf_rst_d = (sel_hf == SEL_HF);
                lf_rst_d = (sel_hf != SEL_HF);
            end
            SETTLE: begin
                if (cnt_done) state_d = ACTIVE;
            end
            default: begin
                // Unreachable encodings: gate power, reset both sides, swap.
                state_d  = PWR_OFF;
                cnt_d    = LD_GUARD;
                hf_rst_d = 1'b0;
                lf_rst_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            state_q  <= STARTUP;
            cnt_q    <= LD_DEB;
            sel_hf   <= SEL_HF;
            hf_rst_n <= 1'b0;
            lf_rst_n <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_hf   <= sel_d;
            hf_rst_n <= hf_rst_d;
            lf_rst_n <= lf_rst_d;
        end
    end

    // Power stays enabled while draining so an aborted drain is invisible.
    assign pwr_gate = !((state_q == ACTIVE) || (state_q == DRAIN));
    assign busy     = (state_q != ACTIVE);

endmodule

// File: tb/tb_hflf_switch_seq.sv
// -----------------------------------------------------------------------------
// tb_hflf_switch_seq
// Directed self-checking bench for hflf_switch_seq with short cycle constants
// (DEBOUNCE 8, DRAIN 16, GUARD 20, SETTLE 4). Drain scenarios are exercised
// when HFLF_DRAIN_WAIT_EN is defined.
// -----------------------------------------------------------------------------
module tb_hflf_switch_seq;

    localparam int SYNC   = 2;
    localparam int DEB    = 8;
    localparam int DRMAX  = 16;
    localparam int GUARD  = 20;
    localparam int SETTLE = 4;
`ifdef HFLF_DRAIN_WAIT_EN
    localparam int DL = 1;
`else
    localparam int DL = 0;
`endif
    // pin edge -> sw_db (SYNC+DEB+1), +1 to leave ACTIVE, +DL for an idle drain
    localparam int GATE_LAT = SYNC + DEB + 2 + DL;

    logic clk, nrst, fpga_switch, hf_ssp_frame, lf_ssp_frame;
    logic sel_hf, pwr_gate, hf_rst_n, lf_rst_n, busy, drain_to;

    int checks = 0;
    int errors = 0;

    hflf_switch_seq #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .DRAIN_MAX       (DRMAX),
        .GUARD_CYCLES    (GUARD),
        .SETTLE_CYCLES   (SETTLE),
        .CNT_W           (16)
    ) dut (
        .ck_1356meg   (clk),
        .nrst         (nrst),
        .fpga_switch  (fpga_switch),
        .hf_ssp_frame (hf_ssp_frame),
        .lf_ssp_frame (lf_ssp_frame),
        .sel_hf       (sel_hf),
        .pwr_gate     (pwr_gate),
        .hf_rst_n     (hf_rst_n),
        .lf_rst_n     (lf_rst_n),
        .busy         (busy),
        .drain_to     (drain_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Invariants, sampled on the falling edge.
    logic prev_sel  = 1'b1;
    logic prev_gate = 1'b1;
    always @(negedge clk) begin
        if (nrst === 1'b1) begin
            checks++;
            if ((hf_rst_n === 1'b1 && lf_rst_n === 1'b1) ||
                (sel_hf !== prev_sel && (prev_gate !== 1'b1 || pwr_gate !== 1'b1))) begin
                errors++;
                $display("FAIL invariant @%0t: sel=%b prev_sel=%b gate=%b prev_gate=%b hf_rst_n=%b lf_rst_n=%b expected one-hot resets and gated select change",
                         $time, sel_hf, prev_sel, pwr_gate, prev_gate, hf_rst_n, lf_rst_n);
            end
        end
        prev_sel  = sel_hf;
        prev_gate = pwr_gate;
    end

    task automatic test_reset();
        int n;
        nrst = 1'b0; fpga_switch = 1'b0; hf_ssp_frame = 1'b0; lf_ssp_frame = 1'b0;
        tick(); tick();
        checks++;
        if ({sel_hf, pwr_gate, hf_rst_n, lf_rst_n, busy, drain_to} !== 6'b110010) begin
            errors++;
            $display("FAIL reset_values: got %b expected 110010", {sel_hf, pwr_gate, hf_rst_n, lf_rst_n, busy, drain_to});
        end
        nrst = 1'b1;
        n = 0;
        while (sel_hf !== 1'b0 && n < 50) begin tick(); n++; end
        checks++;
        if (n > SYNC + DEB + 1) begin
            errors++;
            $display("FAIL startup_select_lat: got %0d cycles expected <= %0d", n, SYNC + DEB + 1);
        end
        checks++;
        if ({hf_rst_n, lf_rst_n, pwr_gate} !== 3'b011) begin
            errors++;
            $display("FAIL startup_resets: got %b expected 011", {hf_rst_n, lf_rst_n, pwr_gate});
        end
        n = 0;
        while (pwr_gate !== 1'b0 && n < 50) begin tick(); n++; end
        checks++;
        if (n !== SETTLE || busy !== 1'b0) begin
            errors++;
            $display("FAIL startup_settle: got %0d cycles busy=%b expected %0d busy=0", n, busy, SETTLE);
        end
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        fpga_switch = 1'b1;
        repeat (5) tick();
        fpga_switch = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy !== 1'b0 || sel_hf !== 1'b0 || pwr_gate !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL glitch_ignored: got %0d disturbed cycles expected 0", bad);
        end
    endtask

    // Full changeover with idle SSP traffic on the active side.
    task automatic run_switch(input logic to_hf, input string tag);
        int n;
        fpga_switch = to_hf;
        n = 0;
        while (pwr_gate !== 1'b1 && n < 100) begin tick(); n++; end
        checks++;
        if (n !== GATE_LAT) begin
            errors++;
            $display("FAIL %s gate_lat: got %0d expected %0d", tag, n, GATE_LAT);
        end
        checks++;
        if ({sel_hf, hf_rst_n, lf_rst_n} !== {~to_hf, 2'b00}) begin
            errors++;
            $display("FAIL %s pwr_off_outputs: got %b expected %b", tag, {sel_hf, hf_rst_n, lf_rst_n}, {~to_hf, 2'b00});
        end
        n = 0;
        while (sel_hf !== to_hf && n < 100) begin tick(); n++; end
        checks++;
        if (n !== GUARD || pwr_gate !== 1'b1) begin
            errors++;
            $display("FAIL %s guard: got %0d cycles gate=%b expected %0d gate=1", tag, n, pwr_gate, GUARD);
        end
        tick();
        checks++;
        if ({hf_rst_n, lf_rst_n} !== (to_hf ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL %s new_side_reset: got %b expected %b", tag, {hf_rst_n, lf_rst_n}, (to_hf ? 2'b10 : 2'b01));
        end
        n = 0;
        while (pwr_gate !== 1'b0 && n < 100) begin tick(); n++; end
        checks++;
        if (n !== SETTLE || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s settle: got %0d cycles busy=%b expected %0d busy=0", tag, n, busy, SETTLE);
        end
    endtask

`ifdef HFLF_DRAIN_WAIT_EN
    // HF active with traffic; pin dips to LF long enough to be accepted, then
    // returns before the drain times out.
    task automatic test_drain_abort();
        int bad, seen_busy;
        bad = 0; seen_busy = 0;
        hf_ssp_frame = 1'b1;
        tick(); tick();
        fpga_switch = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 12) fpga_switch = 1'b1;
            tick();
            if (pwr_gate !== 1'b0 || sel_hf !== 1'b1 || hf_rst_n !== 1'b1) bad++;
            if (busy === 1'b1) seen_busy++;
        end
        checks++;
        if (bad != 0 || seen_busy == 0) begin
            errors++;
            $display("FAIL drain_abort: got %0d disturbed cycles busy_cycles=%0d expected 0 and >0", bad, seen_busy);
        end
        checks++;
        if (busy !== 1'b0 || drain_to !== 1'b0) begin
            errors++;
            $display("FAIL drain_abort_end: got busy=%b drain_to=%b expected 0 0", busy, drain_to);
        end
        hf_ssp_frame = 1'b0;
        tick(); tick();
    endtask

    // LF active with traffic held high: drain expires after DRMAX cycles.
    task automatic test_drain_timeout();
        int n;
        lf_ssp_frame = 1'b1;
        tick();
        fpga_switch = 1'b1;
        n = 0;
        while (pwr_gate !== 1'b1 && n < 100) begin tick(); n++; end
        checks++;
        if (n !== SYNC + DEB + 2 + DRMAX || drain_to !== 1'b1) begin
            errors++;
            $display("FAIL drain_timeout: got %0d cycles drain_to=%b expected %0d drain_to=1", n, drain_to, SYNC + DEB + 2 + DRMAX);
        end
        n = 0;
        while (sel_hf !== 1'b1 && n < 100) begin tick(); n++; end
        checks++;
        if (n !== GUARD) begin
            errors++;
            $display("FAIL drain_timeout_guard: got %0d expected %0d", n, GUARD);
        end
        lf_ssp_frame = 1'b0;
        n = 0;
        while (pwr_gate !== 1'b0 && n < 100) begin tick(); n++; end
        checks++;
        if (n !== SETTLE + 1 || drain_to !== 1'b1 || hf_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL drain_timeout_done: got %0d cycles drain_to=%b hf_rst_n=%b expected %0d 1 1", n, drain_to, hf_rst_n, SETTLE + 1);
        end
    endtask
`endif

    // Pin flips back while committed: new sequence starts right after SETTLE.
    task automatic test_back_to_back();
        int n;
        fpga_switch = 1'b0;
        n = 0;
        while (pwr_gate !== 1'b1 && n < 100) begin tick(); n++; end
        fpga_switch = 1'b1;
        n = 0;
        while (sel_hf !== 1'b0 && n < 100) begin tick(); n++; end
        n = 0;
        while (pwr_gate !== 1'b0 && n < 100) begin tick(); n++; end
        checks++;
        if (n !== SETTLE + 1 || sel_hf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got %0d cycles sel=%b expected %0d sel=0", n, sel_hf, SETTLE + 1);
        end
        n = 0;
        while (pwr_gate !== 1'b1 && n < 100) begin tick(); n++; end
        checks++;
        if (n !== 1 + DL) begin
            errors++;
            $display("FAIL b2b_restart: got %0d ungated cycles expected %0d", n, 1 + DL);
        end
        n = 0;
        while (sel_hf !== 1'b1 && n < 100) begin tick(); n++; end
        n = 0;
        while (pwr_gate !== 1'b0 && n < 100) begin tick(); n++; end
        checks++;
        if ({sel_hf, hf_rst_n, lf_rst_n, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL b2b_final: got %b expected 1100", {sel_hf, hf_rst_n, lf_rst_n, busy});
        end
    endtask

    task automatic test_nrst_mid();
        int n;
        fpga_switch = 1'b0;
        n = 0;
        while (pwr_gate !== 1'b1 && n < 100) begin tick(); n++; end
        repeat (3) tick();
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({sel_hf, pwr_gate, hf_rst_n, lf_rst_n, busy, drain_to} !== 6'b110010) begin
            errors++;
            $display("FAIL nrst_mid_values: got %b expected 110010", {sel_hf, pwr_gate, hf_rst_n, lf_rst_n, busy, drain_to});
        end
        tick();
        nrst = 1'b1;
        n = 0;
        while (sel_hf !== 1'b0 && n < 50) begin tick(); n++; end
        checks++;
        if (n > SYNC + DEB + 1 || {hf_rst_n, lf_rst_n} !== 2'b01) begin
            errors++;
            $display("FAIL nrst_reselect: got %0d cycles resets=%b expected <= %0d resets=01", n, {hf_rst_n, lf_rst_n}, SYNC + DEB + 1);
        end
        n = 0;
        while (pwr_gate !== 1'b0 && n < 50) begin tick(); n++; end
        checks++;
        if (n !== SETTLE) begin
            errors++;
            $display("FAIL nrst_settle: got %0d expected %0d", n, SETTLE);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        run_switch(1'b1, "to_hf");
`ifdef HFLF_DRAIN_WAIT_EN
        test_drain_abort();
        run_switch(1'b0, "to_lf");
        test_drain_timeout();
`else
        run_switch(1'b0, "to_lf");
        run_switch(1'b1, "to_hf2");
        checks++;
        if (drain_to !== 1'b0) begin
            errors++;
            $display("FAIL drain_to_tied: got %b expected 0", drain_to);
        end
`endif
        test_back_to_back();
        test_nrst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
